// File: rtl/raven_bus_pkg.sv
// rtl/raven_bus_pkg.sv - shared types and constants for the 68000 local-bus responders
package raven_bus_pkg;

    // Default width of the per-region wait-state counter.
    localparam int CNT_W_DEFAULT = 4;

    // Width of the latched chip-select region index.
    localparam int REGION_W = 3;

    // Bus-cycle responder states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/dtack_gen_sync2.sv
// rtl/dtack_gen_sync2.sv - two-flop synchronizer, async reset to all ones (negated)
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture; reset to 1 so active-low bus strobes read as negated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dtack_gen.sv
// rtl/dtack_gen.sv - /DTACK responder with per-region wait states; optional DTACK_SYNC_EN input synchronizers
module dtack_gen
    import raven_bus_pkg::*;
#(
    parameter int                        NUM_CS      = 4,
    parameter int                        CNT_W       = CNT_W_DEFAULT,
    parameter logic [NUM_CS*CNT_W-1:0]   WAIT_STATES = 16'h3210
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                as_n,
    input  logic [NUM_CS-1:0]   cs_n,
    output logic                dtack_n,
    output logic                busy,
    output logic [REGION_W-1:0] region
);

    logic              as_i;
    logic [NUM_CS-1:0] cs_i;

`ifdef DTACK_SYNC_EN
    sync2 #(.W(1)) u_sync_as (
        .clk (clk),
        .rst (rst),
        .d   (as_n),
        .q   (as_i)
    );

    sync2 #(.W(NUM_CS)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_i)
    );
`else
    assign as_i = as_n;
    assign cs_i = cs_n;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REGION_W-1:0] region_q, region_d;
    logic                dtack_q, dtack_d;

    logic                hit;
    logic [REGION_W-1:0] hit_idx;
    logic [CNT_W-1:0]    hit_cnt;

    // Priority decode: the lowest asserted chip select wins, with its wait count.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_cnt = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (!cs_i[i]) begin
                hit     = 1'b1;
                hit_idx = REGION_W'(i);
                hit_cnt = WAIT_STATES[i*CNT_W +: CNT_W];
            end
        end
    end

    // State, counter, region and registered /DTACK; reset drops /DTACK at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            region_q <= '0;
            dtack_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            region_q <= region_d;
            dtack_q  <= dtack_d;
        end
    end

    // Next-state logic; an aborted cycle (strobe gone in WAIT) never acknowledges.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        region_d = region_q;
        dtack_d  = dtack_q;
        case (state_q)
            IDLE: begin
                dtack_d = 1'b1;
                if (!as_i && hit) begin
                    region_d = hit_idx;
                    cnt_d    = hit_cnt;
                    if (hit_cnt == '0) begin
                        state_d = ACK;
                        dtack_d = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (as_i) begin
                    state_d = IDLE;
                    dtack_d = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                    dtack_d = 1'b0;
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                if (as_i) begin
                    state_d = IDLE;
                    dtack_d = 1'b1;
                end else begin
                    dtack_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                dtack_d = 1'b1;
            end
        endcase
    end

    assign dtack_n = dtack_q;
    assign busy    = (state_q != IDLE);
    assign region  = region_q;

endmodule

// File: tb/tb_dtack_gen.sv
// tb/tb_dtack_gen.sv - directed self-checking bench for dtack_gen; honours DTACK_SYNC_EN
module tb_dtack_gen;

`ifdef DTACK_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clk;
    logic       rst;
    logic       as_n;
    logic [3:0] cs_n;
    logic       dtack_n;
    logic       busy;
    logic [2:0] region;

    int checks   = 0;
    int failures = 0;

    dtack_gen #(
        .NUM_CS      (4),
        .CNT_W       (4),
        .WAIT_STATES (16'h3210)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .as_n    (as_n),
        .cs_n    (cs_n),
        .dtack_n (dtack_n),
        .busy    (busy),
        .region  (region)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each tick advances to the next falling edge, i.e. just after one rising edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a cycle; on return the FSM has sampled it (edge k).
    task automatic start_cycle(input logic [3:0] cs);
        cs_n = cs;
        as_n = 1'b0;
        tick(L + 1);
    endtask

    // Negate the strobe; on return the FSM has sampled the negation.
    task automatic end_cycle();
        as_n = 1'b1;
        cs_n = 4'b1111;
        tick(L + 1);
    endtask

    initial begin
        rst  = 1'b1;
        as_n = 1'b1;
        cs_n = 4'b1111;
        tick(3);
        check("reset_dtack", dtack_n, 1);
        check("reset_busy", busy, 0);
        check("reset_region", region, 0);
        rst = 1'b0;
        tick(2);

        // Region 0, zero waits: ack at the latch edge, held until strobe negates.
        start_cycle(4'b1110);
        check("r0_dtack_k", dtack_n, 0);
        check("r0_busy_k", busy, 1);
        check("r0_region", region, 0);
        tick(3);
        check("r0_dtack_hold", dtack_n, 0);
        as_n = 1'b1;
        cs_n = 4'b1111;
        tick(L);
        check("r0_dtack_prerel", dtack_n, 0);
        tick(1);
        check("r0_dtack_rel", dtack_n, 1);
        check("r0_busy_rel", busy, 0);
        tick(2);

        // Region 2, two waits: ack from edge k+2.
        start_cycle(4'b1011);
        check("r2_dtack_k", dtack_n, 1);
        check("r2_busy_k", busy, 1);
        check("r2_region", region, 2);
        tick(1);
        check("r2_dtack_k1", dtack_n, 1);
        tick(1);
        check("r2_dtack_k2", dtack_n, 0);
        end_cycle();
        check("r2_dtack_rel", dtack_n, 1);
        check("r2_busy_rel", busy, 0);
        tick(2);

        // Regions 1 and 3 both selected: lowest wins, one wait.
        start_cycle(4'b0101);
        check("pri_region", region, 1);
        check("pri_dtack_k", dtack_n, 1);
        tick(1);
        check("pri_dtack_k1", dtack_n, 0);
        end_cycle();
        check("pri_busy_rel", busy, 0);
        tick(2);

        // Late chip-select change is ignored once the region is latched.
        start_cycle(4'b1011);
        cs_n = 4'b1110;
        tick(1);
        check("latch_region", region, 2);
        check("latch_dtack_k1", dtack_n, 1);
        tick(1);
        check("latch_dtack_k2", dtack_n, 0);
        check("latch_region2", region, 2);
        end_cycle();
        tick(2);

        // Unmapped access: never acknowledged, never busy.
        as_n = 1'b0;
        cs_n = 4'b1111;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("unmapped", {dtack_n, busy}, 2'b10);
        end
        as_n = 1'b1;
        tick(L + 2);

        // Region 3 (three waits) aborted before the count expires.
        start_cycle(4'b0111);
        check("abort_busy_k", busy, 1);
        check("abort_region", region, 3);
        check("abort_dtack_k", dtack_n, 1);
        tick(1 - L / 2);
        as_n = 1'b1;
        cs_n = 4'b1111;
        for (int i = 0; i <= L; i++) begin
            tick(1);
            check("abort_dtack", dtack_n, 1);
        end
        check("abort_busy", busy, 0);
        tick(4);
        check("abort_dtack_after", dtack_n, 1);

        // Reset pulsed during ACK releases /DTACK before the next rising edge.
        start_cycle(4'b1110);
        check("rst_pre_dtack", dtack_n, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_dtack", dtack_n, 1);
        check("rst_async_busy", busy, 0);
        as_n = 1'b1;
        cs_n = 4'b1111;
        #1;
        rst = 1'b0;
        tick(L + 2);
        check("rst_after_dtack", dtack_n, 1);
        check("rst_after_region", region, 0);

        // A fresh cycle after reset works normally.
        start_cycle(4'b1101);
        tick(1);
        check("post_rst_dtack", dtack_n, 0);
        check("post_rst_region", region, 1);
        end_cycle();
        check("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
